// File: rtl/bram_tdp_be_pipe.sv
// bram_tdp_be_pipe: true dual-port byte-enable block RAM with per-port read modes and optional output register.
// Define HIR_BRAM_COLLISION_DETECT_EN to build the sticky same-address collision flag.
module bram_tdp_be_pipe #(
    parameter int SIZE      = 1024,
    parameter int WIDTH     = 32,
    parameter int BYTE_W    = 8,
    parameter int RD_MODE_A = 0,
    parameter int RD_MODE_B = 0,
    parameter int OUT_REG   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    enb,
    input  logic [WIDTH/BYTE_W-1:0] wea,
    input  logic [WIDTH/BYTE_W-1:0] web,
    input  logic [$clog2(SIZE)-1:0] addra,
    input  logic [$clog2(SIZE)-1:0] addrb,
    input  logic [WIDTH-1:0]        dia,
    input  logic [WIDTH-1:0]        dib,
    output logic [WIDTH-1:0]        doa,
    output logic [WIDTH-1:0]        dob,
    output logic                    vala,
    output logic                    valb,
    output logic                    collision,
    input  logic                    clr_collision
);
    localparam int NB = WIDTH / BYTE_W;
    localparam int AW = $clog2(SIZE);
    localparam logic [AW:0] LIM = (AW + 1)'(SIZE);

    logic [WIDTH-1:0]      r_mem [SIZE];
    logic [1:0]            w_en;
    logic [1:0]            w_inr;
    logic [1:0][NB-1:0]    w_we;
    logic [1:0][AW-1:0]    w_addr;
    logic [1:0][WIDTH-1:0] w_di;
    logic [WIDTH-1:0]      w_do [2];
    logic                  w_val [2];

    assign w_en   = {enb, ena};
    assign w_we   = {web, wea};
    assign w_addr = {addrb, addra};
    assign w_di   = {dib, dia};
    assign w_inr  = {{1'b0, addrb} < LIM, {1'b0, addra} < LIM};

    // Port A is applied last so it owns lanes that both ports write on the same edge.
    always_ff @(posedge clk)
        for (int l = 0; l < NB; l++) begin
            if (w_en[1] && w_inr[1] && w_we[1][l]) r_mem[w_addr[1]][l*BYTE_W +: BYTE_W] <= w_di[1][l*BYTE_W +: BYTE_W];
            if (w_en[0] && w_inr[0] && w_we[0][l]) r_mem[w_addr[0]][l*BYTE_W +: BYTE_W] <= w_di[0][l*BYTE_W +: BYTE_W];
        end

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int MODE = (p == 0) ? RD_MODE_A : RD_MODE_B;
        logic [WIDTH-1:0] w_old;
        logic [WIDTH-1:0] w_rd;
        logic [WIDTH-1:0] r_d1;
        logic             w_rdv;
        logic             r_v1;
        assign w_old = w_inr[p] ? r_mem[w_addr[p]] : '0;
        assign w_rdv = w_en[p] && !(MODE == 2 && |w_we[p]);
        // Write-first merges only this port's own lanes; the other port's same-edge write stays invisible.
        always_comb begin
            w_rd = w_old;
            for (int l = 0; l < NB; l++)
                if (MODE == 1 && w_inr[p] && w_we[p][l]) w_rd[l*BYTE_W +: BYTE_W] = w_di[p][l*BYTE_W +: BYTE_W];
        end
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                r_v1 <= 1'b0;
                r_d1 <= '0;
            end else begin
                r_v1 <= w_rdv;
                if (w_rdv) r_d1 <= w_rd;
            end
        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] r_d2;
            logic             r_v2;
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) r_d2 <= r_d1;
                end
            assign w_do[p]  = r_d2;
            assign w_val[p] = r_v2;
        end else begin : g_direct
            assign w_do[p]  = r_d1;
            assign w_val[p] = r_v1;
        end
    end

    assign doa  = w_do[0];
    assign dob  = w_do[1];
    assign vala = w_val[0];
    assign valb = w_val[1];

`ifdef HIR_BRAM_COLLISION_DETECT_EN
    logic r_coll;
    // A set on the same edge as a clear wins.
    always_ff @(posedge clk or posedge rst)
        if (rst) r_coll <= 1'b0;
        else if (ena && enb && addra == addrb && (|wea || |web)) r_coll <= 1'b1;
        else if (clr_collision) r_coll <= 1'b0;
    assign collision = r_coll;
`else
    logic w_unused;
    assign w_unused  = clr_collision;
    assign collision = 1'b0;
`endif
endmodule

// File: tb/tb_bram_tdp_be_pipe.sv
// tb_bram_tdp_be_pipe: two instances (OUT_REG=0 with A write-first/B read-first, OUT_REG=1 with A no-change/B write-first)
// driven in lockstep and checked against a behavioural memory model.
module tb_bram_tdp_be_pipe;
    localparam int SZ = 12;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena, enb, clr_collision;
    logic [3:0]  wea, web, addra, addrb;
    logic [31:0] dia, dib;
    logic [31:0] doa0, dob0, doa1, dob1;
    logic        vala0, valb0, vala1, valb1, coll0, coll1;
    int          n_cmp = 0;
    int          n_err = 0;
    bit [31:0]   mem_m [16];
    bit [31:0]   dl_d [4][2];
    bit          dl_v [4][2];
    bit [31:0]   e_do [4];
    bit          e_val [4];
    bit          e_coll;
    bit          coll_en;
    int          mode [4] = '{1, 0, 2, 1};
    int          lat [4] = '{1, 1, 2, 2};
    bit [31:0]   v [3];

    always #5 clk = ~clk;

    bram_tdp_be_pipe #(.SIZE(SZ), .RD_MODE_A(1), .RD_MODE_B(0), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
        .dia(dia), .dib(dib), .doa(doa0), .dob(dob0), .vala(vala0), .valb(valb0),
        .collision(coll0), .clr_collision(clr_collision));

    bram_tdp_be_pipe #(.SIZE(SZ), .RD_MODE_A(2), .RD_MODE_B(1), .OUT_REG(1)) u1 (
        .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
        .dia(dia), .dib(dib), .doa(doa1), .dob(dob1), .vala(vala1), .valb(valb1),
        .collision(coll1), .clr_collision(clr_collision));

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] we);
        merge = old;
        for (int l = 0; l < 4; l++) if (we[l]) merge[l*8 +: 8] = nw[l*8 +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d [4];
        logic        vv [4];
        d[0] = doa0; d[1] = dob0; d[2] = doa1; d[3] = dob1;
        vv[0] = vala0; vv[1] = valb0; vv[2] = vala1; vv[3] = valb1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s do%0d", tag, c), d[c], e_do[c]);
            chk($sformatf("%s val%0d", tag, c), 32'(vv[c]), 32'(e_val[c]));
        end
        chk({tag, " coll0"}, 32'(coll0), 32'(e_coll));
        chk({tag, " coll1"}, 32'(coll1), 32'(e_coll));
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            dl_v[c][0] = 0; dl_v[c][1] = 0;
            e_do[c] = 0; e_val[c] = 0;
        end
        e_coll = 0;
    endtask

    // Expected results of the coming edge, computed from the memory as it stands before that edge.
    task automatic model_edge();
        bit        en [2];
        bit [3:0]  we [2];
        bit [3:0]  ad [2];
        bit [31:0] di [2];
        en[0] = ena; en[1] = enb; we[0] = wea; we[1] = web;
        ad[0] = addra; ad[1] = addrb; di[0] = dia; di[1] = dib;
        for (int c = 0; c < 4; c++) begin
            int        p;
            bit [31:0] old, res;
            bit        rv;
            p = c % 2;
            old = (int'(ad[p]) < SZ) ? mem_m[ad[p]] : 32'h0;
            rv = en[p] && !(mode[c] == 2 && we[p] != 0);
            res = (int'(ad[p]) >= SZ) ? 32'h0 : (mode[c] == 1) ? merge(old, di[p], we[p]) : old;
            dl_v[c][1] = dl_v[c][0]; dl_d[c][1] = dl_d[c][0];
            dl_v[c][0] = rv; dl_d[c][0] = res;
            e_val[c] = dl_v[c][lat[c]-1];
            if (e_val[c]) e_do[c] = dl_d[c][lat[c]-1];
        end
        if (coll_en && ena && enb && addra == addrb && (wea != 0 || web != 0)) e_coll = 1;
        else if (clr_collision) e_coll = 0;
        if (enb && int'(addrb) < SZ) mem_m[addrb] = merge(mem_m[addrb], dib, web);
        if (ena && int'(addra) < SZ) mem_m[addra] = merge(mem_m[addra], dia, wea);
    endtask

    task automatic cyc(input bit a_en, input bit [3:0] a_we, input bit [3:0] a_ad, input bit [31:0] a_di,
                       input bit b_en, input bit [3:0] b_we, input bit [3:0] b_ad, input bit [31:0] b_di,
                       input bit clr, input bit do_chk, input string tag);
        ena = a_en; wea = a_we; addra = a_ad; dia = a_di;
        enb = b_en; web = b_we; addrb = b_ad; dib = b_di;
        clr_collision = clr;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        if (do_chk) check_all(tag);
    endtask

    // Entered at a falling edge; the reset pulse sits wholly between two rising edges.
    task automatic pulse_rst(input string tag);
        ena = 0; enb = 0; wea = 0; web = 0; clr_collision = 0;
        #2 rst = 1'b1;
        model_reset();
        #1 check_all(tag);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
`ifdef HIR_BRAM_COLLISION_DETECT_EN
        coll_en = 1;
`else
        coll_en = 0;
`endif
        ena = 0; enb = 0; wea = 0; web = 0; addra = 0; addrb = 0; dia = 0; dib = 0; clr_collision = 0;
        model_reset();
        #3 check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < SZ; i += 2)
            cyc(1, 4'hF, 4'(i), $urandom, 1, 4'hF, 4'(i + 1), $urandom, 0, 0, "init");
        pulse_rst("rst_after_init");

        cyc(1, 4'hF, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, "w5");
        cyc(1, 0, 5, 0, 0, 0, 0, 0, 0, 1, "r5");
        chk("req025 doa", doa0, 32'hDEADBEEF);
        chk("req025 vala", 32'(vala0), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "idle");

        cyc(1, 4'hF, 3, 32'h11223344, 0, 0, 0, 0, 0, 1, "w3");
        cyc(1, 4'b0101, 3, 32'hAABBCCDD, 0, 0, 0, 0, 0, 1, "w3be");
        cyc(0, 0, 0, 0, 1, 0, 3, 0, 0, 1, "r3");
        chk("req026 dob", dob0, 32'h11BB33DD);

        cyc(1, 4'hF, 7, 0, 0, 0, 0, 0, 0, 1, "w7z");
        cyc(1, 4'hF, 7, 32'h55, 0, 0, 0, 0, 0, 1, "w7a");
        chk("req027 doa wf", doa0, 32'h55);
        cyc(1, 4'hF, 7, 0, 0, 0, 0, 0, 0, 1, "w7z2");
        cyc(0, 0, 0, 0, 1, 4'hF, 7, 32'h55, 0, 1, "w7b");
        chk("req027 dob rf", dob0, 32'h0);

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "clr");
        cyc(1, 4'hF, 9, 32'h11111111, 1, 4'h3, 9, 32'h22222222, 0, 1, "conflict");
        chk("req028 coll", 32'(coll0), 32'(coll_en));
        cyc(1, 0, 9, 0, 0, 0, 0, 0, 0, 1, "r9");
        chk("req028 data", doa0, 32'h11111111);
        cyc(1, 4'h1, 9, 32'h3, 1, 0, 9, 0, 1, 1, "set_clr");
        chk("req023 set wins", 32'(coll0), 32'(coll_en));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "clr2");
        chk("req023 cleared", 32'(coll0), 0);

        for (int i = 0; i < 3; i++) begin
            v[i] = $urandom;
            cyc(1, 4'hF, 4'(i), v[i], 0, 0, 0, 0, 0, 1, "w012");
        end
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, "rb0");
        chk("req029 no early valb", 32'(valb1), 0);
        cyc(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, "rb1");
        chk("req029 dob c2", dob1, v[0]);
        cyc(0, 0, 0, 0, 1, 0, 2, 0, 0, 1, "rb2");
        chk("req029 dob c3", dob1, v[1]);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "idle");
        chk("req029 dob c4", dob1, v[2]);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "idle");
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, "rb0x");
        cyc(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, "rb1x");
        pulse_rst("req029 rst");
        chk("req029 dob rst", dob1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "flush");
            chk("req020 no valb", 32'(valb1), 0);
        end

        cyc(1, 4'hF, 4, 32'h42, 0, 0, 0, 0, 0, 1, "w4");
        cyc(1, 0, 4, 0, 0, 0, 0, 0, 0, 1, "r4");
        cyc(1, 4'hF, 4, 32'h99, 0, 0, 0, 0, 0, 1, "w4nc");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "idle");
        chk("req030 doa", doa1, 32'h42);
        chk("req030 vala", 32'(vala1), 0);

        cyc(1, 4'hF, 13, 32'h12345678, 0, 0, 0, 0, 0, 1, "oor_w");
        chk("req017 doa", doa0, 0);
        chk("req017 vala", 32'(vala0), 1);
        cyc(0, 0, 0, 0, 1, 0, 13, 0, 0, 1, "oor_r");
        chk("req017 dob", dob0, 0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_rst("rand rst");
            cyc($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 3) == 0, 1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
